// File: rtl/img_sram_rx_tx.sv
// ---------------------------------------------------------------------------
// img_sram_rx_tx
//
// Image buffer between byte-wide pad I/O and the convolution engine's image
// memory. A 16384-byte single-port SRAM (4 banks x 4096 bytes) is shared by a
// receive controller, which writes an nrows x ncols image in raster order, and
// a transmit controller, which reads it back out in the same order. sel_rx
// decides which controller's requests reach the SRAM. The other controller
// still runs, but its requests are dropped.
//
// Pixel (r,c) lives at address {r[6:0], c[6:0]}. addr[13:12] selects the bank
// and addr[11:0] is the in-bank address.
//
// Ports
//   clk      in   sole clock, rising edge
//   rst      in   synchronous active-high reset (FSMs/counters only; the
//                 SRAM contents are kept)
//   sel_rx   in   SRAM owner: 1 = receive controller, 0 = transmit controller
//   nrows    in   image rows (1..128; values above 128 saturate, 0 = no-op)
//   ncols    in   image columns (1..128; values above 128 saturate, 0 = no-op)
//   rx_en    in   single-cycle receive start pulse
//   rx_din   in   input pixel stream
//   rx_busy  out  receive in progress
//   tx_en    in   single-cycle transmit start pulse
//   tx_dout  out  output pixel stream (SRAM read data, held while idle)
//   tx_busy  out  transmit in progress
// ---------------------------------------------------------------------------
module img_sram_rx_tx #(
  parameter int MAX_DIM = 128,
  parameter int DW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sel_rx,
  input  logic [7:0]    nrows,
  input  logic [7:0]    ncols,
  input  logic          rx_en,
  input  logic [DW-1:0] rx_din,
  output logic          rx_busy,
  input  logic          tx_en,
  output logic [DW-1:0] tx_dout,
  output logic          tx_busy
);

  localparam int AW         = 14;
  localparam int BANKS      = 4;
  localparam int BANK_DEPTH = 4096;

  // Clamp a dimension to MAX_DIM.
  function automatic logic [7:0] sat_dim(input logic [7:0] d);
    if (d > 8'(MAX_DIM)) sat_dim = 8'(MAX_DIM);
    else                 sat_dim = d;
  endfunction

  logic [7:0] nr;
  logic [7:0] nc;
  logic [7:0] nr_m1;
  logic [7:0] nc_m1;
  logic       dims_ok;

  always_comb begin
    nr      = sat_dim(nrows);
    nc      = sat_dim(ncols);
    nr_m1   = nr - 8'd1;
    nc_m1   = nc - 8'd1;
    dims_ok = (nr != 8'd0) && (nc != 8'd0);
  end

  // -------------------------------------------------------------------------
  // Receive controller
  // -------------------------------------------------------------------------
  typedef enum logic {RX_IDLE, RX_RUN} rx_state_t;

  rx_state_t         rx_state, rx_state_n;
  logic [7:0]        rx_r, rx_r_n;
  logic [7:0]        rx_c, rx_c_n;
  logic              rx_req;
  logic [AW-1:0]     rx_addr;
  logic              rx_last;

  assign rx_last = (rx_r == nr_m1) && (rx_c == nc_m1);
  assign rx_busy = (rx_state == RX_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_r     <= 8'd0;
      rx_c     <= 8'd0;
    end else begin
      rx_state <= rx_state_n;
      rx_r     <= rx_r_n;
      rx_c     <= rx_c_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_r_n     = rx_r;
    rx_c_n     = rx_c;
    rx_req     = 1'b0;
    rx_addr    = {rx_r[6:0], rx_c[6:0]};
    unique case (rx_state)
      RX_IDLE: begin
        // The start edge itself writes pixel (0,0); the counter then points
        // at pixel 1. A 1x1 image is complete on the start edge.
        if (rx_en && dims_ok) begin
          rx_req  = 1'b1;
          rx_addr = '0;
          if (nr != 8'd1 || nc != 8'd1) begin
            rx_state_n = RX_RUN;
            if (nc == 8'd1) begin
              rx_r_n = 8'd1;
              rx_c_n = 8'd0;
            end else begin
              rx_r_n = 8'd0;
              rx_c_n = 8'd1;
            end
          end
        end
      end
      RX_RUN: begin
        rx_req = 1'b1;
        if (rx_last) begin
          rx_state_n = RX_IDLE;
          rx_r_n     = 8'd0;
          rx_c_n     = 8'd0;
        end else if (rx_c == nc_m1) begin
          rx_r_n = rx_r + 8'd1;
          rx_c_n = 8'd0;
        end else begin
          rx_c_n = rx_c + 8'd1;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Transmit controller
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {TX_IDLE, TX_RUN, TX_DRAIN} tx_state_t;

  tx_state_t         tx_state, tx_state_n;
  logic [7:0]        tx_r, tx_r_n;
  logic [7:0]        tx_c, tx_c_n;
  logic              tx_req;
  logic [AW-1:0]     tx_addr;
  logic              tx_last;

  assign tx_last = (tx_r == nr_m1) && (tx_c == nc_m1);
  assign tx_busy = (tx_state != TX_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_r     <= 8'd0;
      tx_c     <= 8'd0;
    end else begin
      tx_state <= tx_state_n;
      tx_r     <= tx_r_n;
      tx_c     <= tx_c_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_r_n     = tx_r;
    tx_c_n     = tx_c;
    tx_req     = 1'b0;
    tx_addr    = {tx_r[6:0], tx_c[6:0]};
    unique case (tx_state)
      TX_IDLE: begin
        if (tx_en && dims_ok) begin
          tx_state_n = TX_RUN;
          tx_r_n     = 8'd0;
          tx_c_n     = 8'd0;
        end
      end
      TX_RUN: begin
        tx_req = 1'b1;
        if (tx_last) begin
          tx_state_n = TX_DRAIN;
          tx_r_n     = 8'd0;
          tx_c_n     = 8'd0;
        end else if (tx_c == nc_m1) begin
          tx_r_n = tx_r + 8'd1;
          tx_c_n = 8'd0;
        end else begin
          tx_c_n = tx_c + 8'd1;
        end
      end
      // Final read data is on tx_dout during this cycle.
      TX_DRAIN: tx_state_n = TX_IDLE;
      default:  tx_state_n = TX_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Ownership mux and bank decode (stage p0: request issued to the SRAM)
  // -------------------------------------------------------------------------
  logic              sram_req;
  logic              sram_we;
  logic [AW-1:0]     sram_addr;
  logic [DW-1:0]     sram_din;
  logic [1:0]        bank;
  logic [BANKS-1:0]  bank_en;

  // Requests are suppressed while rst is high so a start coinciding with
  // reset leaves the SRAM untouched.
  always_comb begin
    sram_req  = !rst && (sel_rx ? rx_req : tx_req);
    sram_we   = sram_req && sel_rx;
    sram_addr = sel_rx ? rx_addr : tx_addr;
    sram_din  = rx_din;
    bank      = sram_addr[13:12];
    bank_en   = sram_req ? (4'b0001 << bank) : 4'b0000;
  end

  // -------------------------------------------------------------------------
  // SRAM banks (stage p1: read data registered one edge after the address)
  // -------------------------------------------------------------------------
  logic [DW-1:0] mem [BANKS][BANK_DEPTH];
  logic [DW-1:0] bank_dout_p1 [BANKS];
  logic [1:0]    rd_bank_p1;
  logic          vld_p1;

  always_ff @(posedge clk) begin
    for (int b = 0; b < BANKS; b++) begin
      if (bank_en[b]) begin
        if (sram_we) mem[b][sram_addr[11:0]] <= sram_din;
        else         bank_dout_p1[b] <= mem[b][sram_addr[11:0]];
      end
    end
  end

  // Read-side bank select only moves on a read, so tx_dout holds the last
  // pixel read through writes and idle cycles. vld_p1 forces 0 until the
  // first read after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      rd_bank_p1 <= 2'd0;
    end else if (sram_req && !sram_we) begin
      vld_p1     <= 1'b1;
      rd_bank_p1 <= bank;
    end
  end

  assign tx_dout = vld_p1 ? bank_dout_p1[rd_bank_p1] : '0;

endmodule

// File: tb/tb_img_sram_rx_tx.sv
// ---------------------------------------------------------------------------
// tb_img_sram_rx_tx
//
// Directed bench for img_sram_rx_tx: reset state, small and full-size
// loopback, bank edges, zero/oversize dimensions, reset mid-receive, ignored
// starts and back-to-back starts.
// ---------------------------------------------------------------------------
module tb_img_sram_rx_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel_rx;
  logic [7:0] nrows;
  logic [7:0] ncols;
  logic       rx_en;
  logic [7:0] rx_din;
  logic       rx_busy;
  logic       tx_en;
  logic [7:0] tx_dout;
  logic       tx_busy;

  int checks = 0;
  int errors = 0;
  int rx_bc;
  int tx_bc;
  logic [7:0] cap [16384];

  img_sram_rx_tx #(.MAX_DIM(128), .DW(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .sel_rx  (sel_rx),
    .nrows   (nrows),
    .ncols   (ncols),
    .rx_en   (rx_en),
    .rx_din  (rx_din),
    .rx_busy (rx_busy),
    .tx_en   (tx_en),
    .tx_dout (tx_dout),
    .tx_busy (tx_busy)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs written afterwards apply at the
  // following edge and outputs read afterwards reflect the edge just passed.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pat(input int mode, input int p);
    case (mode)
      0:       pat = 8'(p);
      1:       pat = 8'(8'h10 + p);
      2:       pat = 8'(p >> 6);
      3:       pat = 8'(255 - p);
      4:       pat = 8'(8'h40 + p);
      default: pat = 8'(8'hA0 + p);
    endcase
  endfunction

  // Receive npix pixels; counts cycles rx_busy is sampled high. dup_at>0
  // raises rx_en again while pixel dup_at is being written.
  task automatic run_rx(input int npix, input int mode, input int dup_at,
                        output int bc);
    rx_en  = 1'b1;
    rx_din = pat(mode, 0);
    step();
    rx_en = 1'b0;
    bc    = 0;
    for (int p = 1; p < npix + 4; p++) begin
      if (rx_busy) bc++;
      rx_en  = (p == dup_at);
      rx_din = pat(mode, p);
      step();
    end
    rx_en = 1'b0;
  endtask

  // Transmit; pixel p is captured after edge k+1+p. Counts tx_busy-high samples.
  task automatic run_tx(input int npix, output int bc);
    tx_en = 1'b1;
    step();
    tx_en = 1'b0;
    bc    = 0;
    for (int i = 0; i < npix + 6; i++) begin
      if (tx_busy) bc++;
      if (i >= 1 && i <= npix) cap[i-1] = tx_dout;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sel_rx = 1'b1; nrows = 8'd3; ncols = 8'd5;
    rx_en = 1'b0; tx_en = 1'b0; rx_din = 8'h00;
    step(); step(); step();
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_rx_busy got %b want 0", rx_busy); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_tx_busy got %b want 0", tx_busy); end
    checks++; if (tx_dout !== 8'h00) begin errors++; $display("FAIL reset_tx_dout got %h want 00", tx_dout); end
    // Start coinciding with reset is lost.
    rx_en = 1'b1; tx_en = 1'b1;
    step();
    rst = 1'b0; rx_en = 1'b0; tx_en = 1'b0;
    step();
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL rst_en_rx got %b want 0", rx_busy); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL rst_en_tx got %b want 0", tx_busy); end
  endtask

  task automatic test_small();
    nrows = 8'd3; ncols = 8'd5; sel_rx = 1'b1;
    run_rx(15, 1, -1, rx_bc);
    checks++; if (rx_bc !== 14) begin errors++; $display("FAIL small_rx_busy got %0d want 14", rx_bc); end
    sel_rx = 1'b0;
    run_tx(15, tx_bc);
    checks++; if (tx_bc !== 16) begin errors++; $display("FAIL small_tx_busy got %0d want 16", tx_bc); end
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (cap[i] !== 8'(8'h10 + i)) begin errors++; $display("FAIL small_pix[%0d] got %h want %h", i, cap[i], 8'(8'h10 + i)); end
    end
    checks++; if (tx_dout !== 8'h1E) begin errors++; $display("FAIL small_hold got %h want 1e", tx_dout); end
  endtask

  task automatic test_full_loopback();
    nrows = 8'd128; ncols = 8'd128; sel_rx = 1'b1;
    run_rx(16384, 0, -1, rx_bc);
    checks++; if (rx_bc !== 16383) begin errors++; $display("FAIL full_rx_busy got %0d want 16383", rx_bc); end
    sel_rx = 1'b0;
    run_tx(16384, tx_bc);
    checks++; if (tx_bc !== 16385) begin errors++; $display("FAIL full_tx_busy got %0d want 16385", tx_bc); end
    for (int i = 0; i < 16384; i++) begin
      checks++;
      if (cap[i] !== pat(0, i)) begin errors++; $display("FAIL full_pix[%0d] got %h want %h", i, cap[i], pat(0, i)); end
    end
  endtask

  task automatic test_bank_edges();
    int idx [8];
    logic [7:0] exp [8];
    idx = '{0, 4095, 4096, 8191, 8192, 12287, 12288, 16383};
    exp = '{8'h00, 8'h3F, 8'h40, 8'h7F, 8'h80, 8'hBF, 8'hC0, 8'hFF};
    nrows = 8'd128; ncols = 8'd128; sel_rx = 1'b1;
    run_rx(16384, 2, -1, rx_bc);
    sel_rx = 1'b0;
    run_tx(16384, tx_bc);
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (cap[idx[j]] !== exp[j]) begin errors++; $display("FAIL bank_edge[%0d] got %h want %h", idx[j], cap[idx[j]], exp[j]); end
    end
    for (int i = 0; i < 16384; i++) begin
      checks++;
      if (cap[i] !== pat(2, i)) begin errors++; $display("FAIL bank_pix[%0d] got %h want %h", i, cap[i], pat(2, i)); end
    end
  endtask

  task automatic test_dims();
    int seen;
    nrows = 8'd4; ncols = 8'd0; sel_rx = 1'b1;
    rx_en = 1'b1; tx_en = 1'b1;
    step();
    rx_en = 1'b0; tx_en = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (rx_busy || tx_busy) seen++;
      step();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL zero_dim_busy got %0d want 0", seen); end
    nrows = 8'd200; ncols = 8'd2;
    run_rx(256, 0, -1, rx_bc);
    checks++; if (rx_bc !== 255) begin errors++; $display("FAIL oversize_rx_busy got %0d want 255", rx_bc); end
    sel_rx = 1'b0;
    run_tx(256, tx_bc);
    checks++; if (tx_bc !== 257) begin errors++; $display("FAIL oversize_tx_busy got %0d want 257", tx_bc); end
    checks++; if (cap[128] !== 8'h80) begin errors++; $display("FAIL oversize_pix128 got %h want 80", cap[128]); end
    checks++; if (cap[255] !== 8'hFF) begin errors++; $display("FAIL oversize_pix255 got %h want ff", cap[255]); end
  endtask

  task automatic test_reset_mid();
    nrows = 8'd32; ncols = 8'd32; sel_rx = 1'b1;
    rx_en = 1'b1; rx_din = pat(0, 0);
    step();
    rx_en = 1'b0;
    for (int p = 1; p < 500; p++) begin
      rx_din = pat(0, p);
      step();
    end
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b want 1", rx_busy); end
    rst = 1'b1; rx_din = pat(0, 500);
    step();
    rst = 1'b0;
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL mid_busy_after got %b want 0", rx_busy); end
    step();
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL mid_busy_stays got %b want 0", rx_busy); end
    run_rx(1024, 3, -1, rx_bc);
    checks++; if (rx_bc !== 1023) begin errors++; $display("FAIL mid_rx_busy got %0d want 1023", rx_bc); end
    sel_rx = 1'b0;
    run_tx(1024, tx_bc);
    for (int i = 0; i < 1024; i++) begin
      checks++;
      if (cap[i] !== pat(3, i)) begin errors++; $display("FAIL mid_pix[%0d] got %h want %h", i, cap[i], pat(3, i)); end
    end
  endtask

  task automatic test_ignored_starts();
    nrows = 8'd4; ncols = 8'd4; sel_rx = 1'b1;
    run_rx(16, 4, 5, rx_bc);
    checks++; if (rx_bc !== 15) begin errors++; $display("FAIL ign_rx_busy got %0d want 15", rx_bc); end
    sel_rx = 1'b0;
    run_tx(16, tx_bc);
    checks++; if (tx_bc !== 17) begin errors++; $display("FAIL ign_tx_busy got %0d want 17", tx_bc); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (cap[i] !== 8'(8'h40 + i)) begin errors++; $display("FAIL ign_pix[%0d] got %h want %h", i, cap[i], 8'(8'h40 + i)); end
    end
    // Transmit without SRAM ownership: timing only, output holds, no write.
    sel_rx = 1'b1; rx_din = 8'hEE;
    run_tx(16, tx_bc);
    checks++; if (tx_bc !== 17) begin errors++; $display("FAIL unowned_tx_busy got %0d want 17", tx_bc); end
    checks++; if (tx_dout !== 8'h4F) begin errors++; $display("FAIL unowned_hold got %h want 4f", tx_dout); end
    sel_rx = 1'b0;
    run_tx(16, tx_bc);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (cap[i] !== 8'(8'h40 + i)) begin errors++; $display("FAIL unowned_pix[%0d] got %h want %h", i, cap[i], 8'(8'h40 + i)); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b2b [4];
    b2b = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
    nrows = 8'd2; ncols = 8'd2; sel_rx = 1'b1;
    rx_en = 1'b1; rx_din = 8'hA0;
    step();
    rx_en = 1'b0; rx_din = 8'hA1; step();
    rx_din = 8'hA2; step();
    rx_din = 8'hA3; step();
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL b2b_first_done got %b want 0", rx_busy); end
    rx_en = 1'b1; rx_din = 8'hB0;
    step();
    rx_en = 1'b0;
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL b2b_restart got %b want 1", rx_busy); end
    rx_din = 8'hB1; step();
    rx_din = 8'hB2; step();
    rx_din = 8'hB3; step();
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL b2b_second_done got %b want 0", rx_busy); end
    sel_rx = 1'b0;
    run_tx(4, tx_bc);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cap[i] !== b2b[i]) begin errors++; $display("FAIL b2b_pix[%0d] got %h want %h", i, cap[i], b2b[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_small();
    test_full_loopback();
    test_bank_edges();
    test_dims();
    test_reset_mid();
    test_ignored_starts();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
